// File: rtl/debug_sequencer.sv
// Run-control and snapshot-dump sequencer between the UART Rx/Tx and the MIPS_DLX core.
// Optional: define DEBUG_SEQ_ECHO_EN to transmit every accepted command byte back before acting on it.
module debug_sequencer #(
  parameter int SNAP_W     = 322,
  parameter int SNAP_BYTES = (SNAP_W + 7) / 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_done_i,
  input  logic              tx_done_i,
  input  logic [SNAP_W-1:0] snapshot_i,
  input  logic              cpu_halt_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  output logic              cpu_en_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic [3:0]        state_o
);

  localparam int SHIFT_W = 8 * SNAP_BYTES;
  localparam int IDX_W   = $clog2(SNAP_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_BYTES - 1);

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_CRST = 8'h43;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_CRST,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX,
    ST_ECHO,
    ST_ECHO_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  function automatic logic is_idle_cmd(input logic [7:0] b);
    return (b == CMD_RUN) || (b == CMD_STEP) || (b == CMD_DUMP) || (b == CMD_CRST);
  endfunction

  // 'D' and 'H' both lead straight into a dump.
  function automatic state_e cmd_target(input logic [7:0] b);
    state_e s;
    case (b)
      CMD_RUN:  s = ST_RUN;
      CMD_STEP: s = ST_STEP;
      CMD_CRST: s = ST_CRST;
      default:  s = ST_LATCH;
    endcase
    return s;
  endfunction

`ifdef DEBUG_SEQ_ECHO_EN
  logic [7:0] cmd_q, cmd_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
`ifdef DEBUG_SEQ_ECHO_EN
      cmd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef DEBUG_SEQ_ECHO_EN
      cmd_q   <= cmd_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_done_i && is_idle_cmd(rx_data_i)) begin
`ifdef DEBUG_SEQ_ECHO_EN
          state_d = ST_ECHO;
`else
          state_d = cmd_target(rx_data_i);
`endif
        end
      end
      ST_RUN: begin
        if (rx_done_i && (rx_data_i == CMD_HALT)) begin
`ifdef DEBUG_SEQ_ECHO_EN
          state_d = ST_ECHO;
`else
          state_d = ST_LATCH;
`endif
        end else if (cpu_halt_i) begin
          state_d = ST_LATCH;
        end
      end
      ST_STEP:    state_d = ST_LATCH;
      ST_CRST:    state_d = ST_IDLE;
      ST_LATCH:   state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done_i) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_SEND;
      end
`ifdef DEBUG_SEQ_ECHO_EN
      ST_ECHO:      state_d = ST_ECHO_WAIT;
      ST_ECHO_WAIT: begin
        if (tx_done_i) state_d = cmd_target(cmd_q);
      end
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // Snapshot shift register and byte index
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == ST_LATCH) begin
      shift_d = SHIFT_W'(snapshot_i);
      idx_d   = '0;
    end else if ((state_q == ST_WAIT_TX) && tx_done_i) begin
      shift_d = shift_q >> 8;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

`ifdef DEBUG_SEQ_ECHO_EN
  always_comb begin
    cmd_d = cmd_q;
    if ((state_q == ST_IDLE) && rx_done_i && is_idle_cmd(rx_data_i)) begin
      cmd_d = rx_data_i;
    end else if ((state_q == ST_RUN) && rx_done_i && (rx_data_i == CMD_HALT)) begin
      cmd_d = CMD_HALT;
    end
  end
`endif

  // Outputs are pure functions of the registered state.
  always_comb begin
    cpu_en_o    = (state_q == ST_RUN) || (state_q == ST_STEP);
    cpu_reset_o = (state_q == ST_CRST);
    busy_o      = (state_q != ST_IDLE);
    state_o     = state_q;
`ifdef DEBUG_SEQ_ECHO_EN
    tx_start_o  = (state_q == ST_SEND) || (state_q == ST_ECHO);
    tx_data_o   = ((state_q == ST_ECHO) || (state_q == ST_ECHO_WAIT)) ? cmd_q : shift_q[7:0];
`else
    tx_start_o  = (state_q == ST_SEND);
    tx_data_o   = shift_q[7:0];
`endif
  end

endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

UART-driven run-control and snapshot sequencer for the MIPS_DLX core. It decodes command bytes from the UART receiver and gates the core's clock enable for run, halt and single-step. It also pulses the core's reset on command. After each stop it latches the core's debug snapshot and streams it byte-by-byte through the UART transmitter using the tx_start/tx_done handshake. It sits between Rx/Tx and the core in the MIPS_UART top level, on the reduced clock `clk`.

## Interface
- SNAP_W, 322: width of the debug snapshot bus.
- SNAP_BYTES, 41: bytes per dump, ceil(SNAP_W/8); the last byte is zero-padded in its upper bits.

- clock  in  1  system clock (reduced clock); all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- rx_data  in  8  received byte; valid when rx_done=1.
- rx_done  in  1  one-cycle pulse per received byte.
- tx_done  in  1  one-cycle pulse when the transmitter finishes a byte.
- snapshot  in  SNAP_W  core debug bus (PC, registers, latches).
- cpu_halt  in  1  core reports a halt instruction retired (level).
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- cpu_en  out  1  core clock enable; the core advances one instruction per cycle with cpu_en=1.
- cpu_reset  out  1  one-cycle reset pulse to the core.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values: state=IDLE, cpu_en=0, cpu_reset=0, tx_start=0, tx_data=0x00, busy=0, byte index=0, shift register=0.
- Commands are accepted only in IDLE, plus 'H' in RUN:
  - 'R' 0x52 → RUN.
  - 'S' 0x53 → STEP.
  - 'D' 0x44 → LATCH (dump without advancing the core).
  - 'C' 0x43 → CRST.
  - Any other byte is ignored; state stays IDLE.
- RUN: cpu_en=1 every cycle.
  - Exit to LATCH when rx_done with 'H' 0x48, or when cpu_halt=1.
  - cpu_en is 0 in the exit cycle's successor.
  - Other bytes received in RUN are ignored.
- STEP: cpu_en=1 for exactly one cycle, then LATCH.
- CRST: cpu_reset=1 for exactly one cycle, cpu_en=0, then IDLE; no dump.
- LATCH: capture snapshot into the SNAP_BYTES×8 shift register (zero-extended) and clear the byte index, then SEND.
- SEND: tx_data=shift[7:0], tx_start=1 for one cycle, then WAIT_TX.
- WAIT_TX: on tx_done, shift right by 8 and increment the index.
  - If index was SNAP_BYTES-1, go to IDLE.
  - Otherwise go to SEND.
- Byte order: byte 0 = snapshot[7:0], and so on; the final byte carries snapshot[SNAP_W-1:8*(SNAP_BYTES-1)] zero-padded.
- All rx_done pulses outside IDLE/RUN are dropped. They are not queued.
- tx_done outside WAIT_TX (and outside ECHO_WAIT) is ignored.
- cpu_halt already high when 'R' arrives: RUN lasts one cycle (one instruction executes), then LATCH.
- Reset mid-dump: abort immediately, all outputs return to their reset values next cycle, and no further tx_start is issued.

## Timing
- rx_done of a command at cycle T → state change visible at T+1.
- STEP: cpu_en=1 in cycle T+1 only, LATCH at T+2, first tx_start at T+3.
- 'D': LATCH at T+1, first tx_start at T+2.
- RUN exit (halt byte or cpu_halt sampled at T): cpu_en=0 from T+1, LATCH at T+1, first tx_start at T+2.
- tx_done at cycle U (not last byte) → next tx_start at U+1.
- After the last byte's tx_done at U, IDLE at U+1; a command byte at U+1 is accepted.
- 'C': cpu_reset=1 at T+1, IDLE at T+2.
- reset and rx_done in the same cycle: reset wins and the byte is lost.

## Configuration
- DEBUG_SEQ_ECHO_EN defined:
  - Every accepted command byte ('R','S','D','C', and 'H' in RUN) is first transmitted back (states ECHO, ECHO_WAIT).
  - tx_start with tx_data=command byte at T+1.
  - The action begins the cycle after the echo's tx_done, and all timings above shift by that delay.
  - For 'H', cpu_en drops at T+1 regardless; the dump starts after the echo.
  - cpu_halt-triggered stops are not echoed.
- Undefined: no echo; timings exactly as above.

## Test plan
- Reset, then idle 20 cycles → cpu_en=0, tx_start=0, busy=0, tx_data=0x00.
- 'S' with snapshot=322'h1_0000…_00A5 (byte0=0xA5), tx_done returned 5 cycles after each tx_start → cpu_en high exactly 1 cycle; 41 tx_start pulses; byte0=0xA5; byte40 upper 6 bits zero; busy low after the 41st tx_done.
- 'R', wait 100 cycles, 'H' → cpu_en high exactly 100+1 cycles, then a 41-byte dump. Send 'R', then raise cpu_halt after 7 cycles → cpu_en high 7 cycles, then dump.
- 'C' → cpu_reset one-cycle pulse at T+1, no tx_start. Byte 0x41 'A' → no state change, busy stays 0.
- 'D' during an active dump (byte 10 in flight), then reset asserted at byte 20 → the extra 'D' is ignored; after reset, no tx_start and all outputs at reset values.
- With DEBUG_SEQ_ECHO_EN: 'S' → first tx_start carries 0x53; cpu_en pulses the cycle after its tx_done; 41 dump bytes follow.
